// File: rtl/char_osd_pkg.sv
// Shared constants, state encoding and helpers for the character OSD loader
// and buffer reader.
package char_osd_pkg;

  localparam logic [7:0] MAGIC      = 8'hA5;
  localparam logic [7:0] CMD_CONFIG = 8'h01;
  localparam logic [7:0] CMD_TEXT   = 8'h02;

  localparam int DEF_START_X = 10;
  localparam int DEF_START_Y = 10;
  localparam int DEF_CHAR_W  = 10;
  localparam int DEF_CHAR_H  = 20;
  localparam int DEF_MARGIN  = 10;

  localparam int CFG_BYTES = 12;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_CFG,
    S_CLR_HI,
    S_CLR_LO,
    S_TEXT,
    S_LEN_HI,
    S_LEN_LO,
    S_DRAIN
  } state_t;

  // Geometry fields are 16-bit big-endian on the wire; only 11 bits are kept.
  function automatic logic [10:0] field11(input logic [7:0] hi, input logic [7:0] lo);
    return 11'({hi, lo});
  endfunction

  function automatic logic accepts_bytes(input state_t s);
    return (s == S_IDLE) || (s == S_CMD) || (s == S_CFG) ||
           (s == S_TEXT) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/char_osd_cfg_shadow.sv
// Collects the 12 CONFIG payload bytes and commits all six geometry
// registers in a single cycle.
module char_osd_cfg_shadow
  import char_osd_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 1920,
  parameter int SCREEN_HEIGHT = 1080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  wr_idx,
  input  logic [7:0]  wr_data,
  input  logic        commit,
  output logic [10:0] cfg_start_posX,
  output logic [10:0] cfg_start_posY,
  output logic [10:0] cfg_end_posX,
  output logic [10:0] cfg_end_posY,
  output logic [10:0] cfg_char_width,
  output logic [10:0] cfg_char_height
);

  // The 12th byte is taken straight from the stream at commit time.
  logic [7:0] shadow [0:CFG_BYTES-2];

  always_ff @(posedge clk) begin
    if (wr_en && (wr_idx < 4'(CFG_BYTES - 1)))
      shadow[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_start_posX  <= 11'(DEF_START_X);
      cfg_start_posY  <= 11'(DEF_START_Y);
      cfg_end_posX    <= 11'(SCREEN_WIDTH - DEF_MARGIN);
      cfg_end_posY    <= 11'(SCREEN_HEIGHT - DEF_MARGIN);
      cfg_char_width  <= 11'(DEF_CHAR_W);
      cfg_char_height <= 11'(DEF_CHAR_H);
    end else if (commit) begin
      cfg_start_posX  <= field11(shadow[0], shadow[1]);
      cfg_start_posY  <= field11(shadow[2], shadow[3]);
      cfg_end_posX    <= field11(shadow[4], shadow[5]);
      cfg_end_posY    <= field11(shadow[6], shadow[7]);
      cfg_char_width  <= field11(shadow[8], shadow[9]);
      cfg_char_height <= field11(shadow[10], wr_data);
    end
  end

endmodule

// File: rtl/char_osd_loader.sv
// Packet-driven loader: parses CONFIG/TEXT packets and writes the character
// buffer, publishing the length word only after the text is complete.
module char_osd_loader
  import char_osd_pkg::*;
#(
  parameter int STRLENDATA_SAVED_ADDR  = 1023,
  parameter int CHAR_BUFFER_ADDR_WIDTH = 12,
  parameter int SCREEN_WIDTH           = 1920,
  parameter int SCREEN_HEIGHT          = 1080
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [7:0]                        s_data,
  input  logic                              s_valid,
  input  logic                              s_last,
  output logic                              s_ready,
  output logic                              ram_we,
  output logic [CHAR_BUFFER_ADDR_WIDTH-1:0] ram_waddr,
  output logic [7:0]                        ram_wdata,
  output logic [10:0]                       cfg_start_posX,
  output logic [10:0]                       cfg_start_posY,
  output logic [10:0]                       cfg_end_posX,
  output logic [10:0]                       cfg_end_posY,
  output logic [10:0]                       cfg_char_width,
  output logic [10:0]                       cfg_char_height,
  output logic                              busy,
  output logic                              err
);

  localparam int AW = CHAR_BUFFER_ADDR_WIDTH;
  localparam logic [AW-1:0] LEN_HI_ADDR = AW'(STRLENDATA_SAVED_ADDR);
  localparam logic [AW-1:0] LEN_LO_ADDR = AW'(STRLENDATA_SAVED_ADDR + 1);
  localparam logic [15:0]   TEXT_MAX    = 16'(STRLENDATA_SAVED_ADDR);

  state_t      state, state_nxt;
  logic        accept;
  logic [3:0]  cfg_cnt, cfg_cnt_nxt;
  logic [15:0] text_len, text_len_nxt;
  logic        last_seen, last_seen_nxt;
  logic        ovf_flag, ovf_flag_nxt;

  logic          we_nxt;
  logic [AW-1:0] waddr_nxt;
  logic [7:0]    wdata_nxt;
  logic          err_nxt;
  logic          cfg_wr;
  logic          commit;

  assign accept = s_valid & s_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cfg_cnt   <= '0;
      text_len  <= '0;
      last_seen <= 1'b0;
      ovf_flag  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_cnt   <= cfg_cnt_nxt;
      text_len  <= text_len_nxt;
      last_seen <= last_seen_nxt;
      ovf_flag  <= ovf_flag_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cfg_cnt_nxt   = cfg_cnt;
    text_len_nxt  = text_len;
    last_seen_nxt = last_seen;
    ovf_flag_nxt  = ovf_flag;
    unique case (state)
      S_IDLE: if (accept) begin
        // A lone magic byte with last is a complete (bad) packet.
        if (s_last)               state_nxt = S_IDLE;
        else if (s_data == MAGIC) state_nxt = S_CMD;
        else                      state_nxt = S_DRAIN;
      end
      S_CMD: if (accept) begin
        case (s_data)
          CMD_CONFIG: begin
            state_nxt   = s_last ? S_IDLE : S_CFG;
            cfg_cnt_nxt = '0;
          end
          CMD_TEXT: begin
            state_nxt     = S_CLR_HI;
            last_seen_nxt = s_last;
            text_len_nxt  = '0;
            ovf_flag_nxt  = 1'b0;
          end
          default: state_nxt = s_last ? S_IDLE : S_DRAIN;
        endcase
      end
      S_CFG: if (accept) begin
        if (s_last)                       state_nxt = S_IDLE;
        else if (cfg_cnt == 4'(CFG_BYTES)) state_nxt = S_DRAIN;
        else                              cfg_cnt_nxt = cfg_cnt + 4'd1;
      end
      S_CLR_HI: state_nxt = S_CLR_LO;
      S_CLR_LO: state_nxt = last_seen ? S_LEN_HI : S_TEXT;
      S_TEXT: if (accept) begin
        if (text_len != TEXT_MAX) text_len_nxt = text_len + 16'd1;
        else                      ovf_flag_nxt = 1'b1;
        if (s_last) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: state_nxt = S_LEN_LO;
      S_LEN_LO: state_nxt = S_IDLE;
      S_DRAIN:  if (accept && s_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    we_nxt    = 1'b0;
    waddr_nxt = ram_waddr;
    wdata_nxt = ram_wdata;
    err_nxt   = 1'b0;
    cfg_wr    = 1'b0;
    commit    = 1'b0;
    unique case (state)
      S_IDLE: err_nxt = accept && ((s_data != MAGIC) || s_last);
      S_CMD: if (accept) begin
        case (s_data)
          CMD_CONFIG: err_nxt = s_last;
          CMD_TEXT: begin
            we_nxt    = 1'b1;
            waddr_nxt = LEN_HI_ADDR;
            wdata_nxt = 8'h00;
          end
          default: err_nxt = 1'b1;
        endcase
      end
      S_CFG: if (accept) begin
        cfg_wr = 1'b1;
        if (s_last) begin
          commit  = (cfg_cnt == 4'(CFG_BYTES - 1));
          err_nxt = (cfg_cnt != 4'(CFG_BYTES - 1));
        end else begin
          err_nxt = (cfg_cnt == 4'(CFG_BYTES));
        end
      end
      S_CLR_HI: begin
        we_nxt    = 1'b1;
        waddr_nxt = LEN_LO_ADDR;
        wdata_nxt = 8'h00;
      end
      S_TEXT: if (accept) begin
        if (text_len != TEXT_MAX) begin
          we_nxt    = 1'b1;
          waddr_nxt = text_len[AW-1:0];
          wdata_nxt = s_data;
        end else begin
          err_nxt = !ovf_flag;
        end
      end
      S_LEN_HI: begin
        we_nxt    = 1'b1;
        waddr_nxt = LEN_HI_ADDR;
        wdata_nxt = text_len[15:8];
      end
      S_LEN_LO: begin
        we_nxt    = 1'b1;
        waddr_nxt = LEN_LO_ADDR;
        wdata_nxt = text_len[7:0];
      end
      default: ;
    endcase
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      s_ready   <= 1'b1;
      busy      <= 1'b0;
      err       <= 1'b0;
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
    end else begin
      s_ready   <= accepts_bytes(state_nxt);
      busy      <= (state_nxt != S_IDLE);
      err       <= err_nxt;
      ram_we    <= we_nxt;
      ram_waddr <= waddr_nxt;
      ram_wdata <= wdata_nxt;
    end
  end

  char_osd_cfg_shadow #(
    .SCREEN_WIDTH  (SCREEN_WIDTH),
    .SCREEN_HEIGHT (SCREEN_HEIGHT)
  ) u_cfg_shadow (
    .clk             (clk),
    .reset           (reset),
    .wr_en           (cfg_wr),
    .wr_idx          (cfg_cnt),
    .wr_data         (s_data),
    .commit          (commit),
    .cfg_start_posX  (cfg_start_posX),
    .cfg_start_posY  (cfg_start_posY),
    .cfg_end_posX    (cfg_end_posX),
    .cfg_end_posY    (cfg_end_posY),
    .cfg_char_width  (cfg_char_width),
    .cfg_char_height (cfg_char_height)
  );

endmodule

// File: tb/tb_char_osd_loader.sv
// Scoreboard bench: two loaders (full-size and a tiny 8-byte buffer) share one
// byte stream; a packet-level model predicts writes, cfg commits and errors.
module tb_char_osd_loader;

  localparam int HA = 1023, AWA = 12;
  localparam int HB = 8,    AWB = 4;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] s_data;
  logic s_valid, s_last;

  logic s_ready_a, ram_we_a, busy_a, err_a;
  logic [AWA-1:0] ram_waddr_a;
  logic [7:0] ram_wdata_a;
  logic [5:0][10:0] cfg_a;

  logic s_ready_b, ram_we_b, busy_b, err_b;
  logic [AWB-1:0] ram_waddr_b;
  logic [7:0] ram_wdata_b;
  logic [5:0][10:0] cfg_b;

  always #5 clk = ~clk;

  char_osd_loader #(.STRLENDATA_SAVED_ADDR(HA), .CHAR_BUFFER_ADDR_WIDTH(AWA)) dut_a (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready_a), .ram_we(ram_we_a), .ram_waddr(ram_waddr_a), .ram_wdata(ram_wdata_a),
    .cfg_start_posX(cfg_a[0]), .cfg_start_posY(cfg_a[1]), .cfg_end_posX(cfg_a[2]),
    .cfg_end_posY(cfg_a[3]), .cfg_char_width(cfg_a[4]), .cfg_char_height(cfg_a[5]),
    .busy(busy_a), .err(err_a));

  char_osd_loader #(.STRLENDATA_SAVED_ADDR(HB), .CHAR_BUFFER_ADDR_WIDTH(AWB)) dut_b (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready_b), .ram_we(ram_we_b), .ram_waddr(ram_waddr_b), .ram_wdata(ram_wdata_b),
    .cfg_start_posX(cfg_b[0]), .cfg_start_posY(cfg_b[1]), .cfg_end_posX(cfg_b[2]),
    .cfg_end_posY(cfg_b[3]), .cfg_char_width(cfg_b[4]), .cfg_char_height(cfg_b[5]),
    .busy(busy_b), .err(err_b));

  typedef logic [7:0] bq_t[$];
  typedef logic [19:0] wr_t;  // {addr[11:0], data[7:0]}

  int n_checks = 0;
  int n_fail = 0;
  int err_cnt_a, err_cnt_b;
  wr_t q_a[$], q_b[$];
  logic [5:0][10:0] cq_a[$], cq_b[$];
  logic [5:0][10:0] model_cfg, prev_a, prev_b;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic push_wr(input int d, input int a, input int v);
    wr_t w;
    w = {12'(a), 8'(v)};
    if (d == 1) q_b.push_back(w);
    else        q_a.push_back(w);
  endtask

  // Packet-level reference: what a whole packet should do to each buffer.
  task automatic model_pkt(input bq_t pkt, output int ea, output int eb);
    int n;
    n = pkt.size();
    ea = 0;
    eb = 0;
    if (pkt[0] != 8'hA5 || n == 1) begin
      ea = 1; eb = 1;
    end else if (pkt[1] == 8'h01) begin
      if (n - 2 == 12) begin
        logic [5:0][10:0] nc;
        for (int f = 0; f < 6; f++) nc[f] = 11'({pkt[2+2*f], pkt[3+2*f]});
        if (nc != model_cfg) begin
          cq_a.push_back(nc);
          cq_b.push_back(nc);
          model_cfg = nc;
        end
      end else begin
        ea = 1; eb = 1;
      end
    end else if (pkt[1] == 8'h02) begin
      int t;
      t = n - 2;
      for (int d = 0; d < 2; d++) begin
        int lim, kept;
        lim = (d == 1) ? HB : HA;
        kept = (t < lim) ? t : lim;
        push_wr(d, lim, 0);
        push_wr(d, lim + 1, 0);
        for (int i = 0; i < kept; i++) push_wr(d, i, pkt[2+i]);
        push_wr(d, lim, kept / 256);
        push_wr(d, lim + 1, kept % 256);
        if (t > lim) begin
          if (d == 1) eb = 1; else ea = 1;
        end
      end
    end else begin
      ea = 1; eb = 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    bit ok;
    int guard;
    guard = 0;
    while ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    do begin
      ok = s_ready_a;
      @(posedge clk); #1;
      guard++;
    end while (!ok && guard < 64);
    if (!ok) fail_now("accept_timeout");
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic send_pkt(input bq_t pkt, input string tag);
    int ea, eb, g;
    model_pkt(pkt, ea, eb);
    err_cnt_a = 0;
    err_cnt_b = 0;
    for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], i == pkt.size() - 1);
    g = 0;
    while ((busy_a || busy_b) && g < 100) begin @(posedge clk); #1; g++; end
    if (g >= 100) fail_now({tag, "_busy_timeout"});
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_err_count_a"}, err_cnt_a, ea);
    check({tag, "_err_count_b"}, err_cnt_b, eb);
    check({tag, "_writes_left_a"}, q_a.size(), 0);
    check({tag, "_writes_left_b"}, q_b.size(), 0);
    check({tag, "_cfg_left"}, cq_a.size() + cq_b.size(), 0);
    check({tag, "_idle"}, {busy_a, busy_b, s_ready_a, s_ready_b}, 4'b0011);
    q_a.delete(); q_b.delete(); cq_a.delete(); cq_b.delete();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_a = cfg_a;
      prev_b = cfg_b;
    end else begin
      if (ram_we_a) begin
        if (q_a.size() == 0) fail_now("unexpected_write_a");
        else begin
          wr_t e;
          e = q_a.pop_front();
          check("write_a", {ram_waddr_a, ram_wdata_a}, e);
        end
      end
      if (ram_we_b) begin
        if (q_b.size() == 0) fail_now("unexpected_write_b");
        else begin
          wr_t e;
          e = q_b.pop_front();
          check("write_b", {8'b0, ram_waddr_b, ram_wdata_b}, e);
        end
      end
      if (err_a) err_cnt_a++;
      if (err_b) err_cnt_b++;
      if (cfg_a !== prev_a) begin
        if (cq_a.size() == 0) fail_now("unexpected_cfg_a");
        else check("cfg_commit_a", cfg_a, cq_a.pop_front());
        prev_a = cfg_a;
      end
      if (cfg_b !== prev_b) begin
        if (cq_b.size() == 0) fail_now("unexpected_cfg_b");
        else check("cfg_commit_b", cfg_b, cq_b.pop_front());
        prev_b = cfg_b;
      end
    end
  end

  initial begin
    bq_t p;
    model_cfg[0] = 11'd10;
    model_cfg[1] = 11'd10;
    model_cfg[2] = 11'd1910;
    model_cfg[3] = 11'd1070;
    model_cfg[4] = 11'd10;
    model_cfg[5] = 11'd20;
    reset = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;

    check("reset_cfg_a", cfg_a, model_cfg);
    check("reset_cfg_b", cfg_b, model_cfg);
    check("reset_ctrl_a", {s_ready_a, ram_we_a, busy_a, err_a}, 4'b1000);
    check("reset_ctrl_b", {s_ready_b, ram_we_b, busy_b, err_b}, 4'b1000);
    check("reset_wr_a", {ram_waddr_a, ram_wdata_a}, 20'h0);

    p = '{8'hA5, 8'h01, 8'h00, 8'h64, 8'h00, 8'h32, 8'h07, 8'h00,
          8'h04, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h18};
    send_pkt(p, "config");
    check("config_values", cfg_a, {11'd24, 11'd12, 11'd1024, 11'd1792, 11'd50, 11'd100});

    p = '{8'hA5, 8'h02, 8'h48, 8'h49, 8'h0A};
    send_pkt(p, "text");

    p = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_pkt(p, "short_config");

    p = '{8'h5A, 8'h02, 8'h41, 8'h42};
    send_pkt(p, "bad_magic");

    p = '{8'hA5, 8'h02, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
          8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    send_pkt(p, "overflow");

    p = '{8'hA5, 8'h02};
    send_pkt(p, "empty_text");

    for (int k = 0; k < 80; k++) begin
      int kind, len;
      p.delete();
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin
          p.push_back(8'hA5); p.push_back(8'h01);
          for (int i = 0; i < 12; i++) p.push_back(8'($urandom));
        end
        1: begin
          len = $urandom_range(0, 14);
          if (len >= 12) len = len + 1;
          p.push_back(8'hA5); p.push_back(8'h01);
          for (int i = 0; i < len; i++) p.push_back(8'($urandom));
        end
        2, 3: begin
          len = $urandom_range(0, 12);
          p.push_back(8'hA5); p.push_back(8'h02);
          for (int i = 0; i < len; i++) p.push_back(8'($urandom));
        end
        4: begin
          logic [7:0] b;
          b = 8'($urandom);
          if (b == 8'hA5) b = 8'h5A;
          p.push_back(b);
          len = $urandom_range(0, 4);
          for (int i = 0; i < len; i++) p.push_back(8'($urandom));
        end
        default: begin
          logic [7:0] c;
          p.push_back(8'hA5);
          if ($urandom_range(0, 3) != 0) begin
            c = 8'($urandom_range(3, 255));
            p.push_back(c);
            len = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) p.push_back(8'($urandom));
          end
        end
      endcase
      send_pkt(p, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
